// File: rtl/color_classifier_hyst.sv
// Colour classifier: per-channel threshold with hysteresis and an N-sample stability filter.
// The committed 3-bit colour code drives the RGB indicator with a selectable polarity.
module color_classifier_hyst #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TH_R       = 20,
    parameter int unsigned TH_G       = 30,
    parameter int unsigned TH_B       = 30,
    parameter int unsigned HYST       = 5,
    parameter int unsigned STABLE_N   = 3,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] red_norm,
    input  logic [WIDTH-1:0] green_norm,
    input  logic [WIDTH-1:0] blue_norm,
    output logic [2:0]       color,
    output logic             color_valid,
    output logic             color_change
);

    localparam int unsigned SN = (STABLE_N == 0) ? 1 : STABLE_N;
    localparam int unsigned CW = $clog2(SN + 1);
    localparam logic [CW-1:0] SN_W = CW'(SN);

    localparam logic [WIDTH-1:0] SET_R = WIDTH'(TH_R);
    localparam logic [WIDTH-1:0] SET_G = WIDTH'(TH_G);
    localparam logic [WIDTH-1:0] SET_B = WIDTH'(TH_B);
    localparam logic [WIDTH-1:0] CLR_R = (TH_R >= HYST) ? WIDTH'(TH_R - HYST) : '0;
    localparam logic [WIDTH-1:0] CLR_G = (TH_G >= HYST) ? WIDTH'(TH_G - HYST) : '0;
    localparam logic [WIDTH-1:0] CLR_B = (TH_B >= HYST) ? WIDTH'(TH_B - HYST) : '0;

    logic [2:0]    r_on;
    logic [2:0]    r_cand;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_code;
    logic          r_valid;
    logic          r_change;

    logic [2:0]    w_next_on;
    logic [CW-1:0] w_cnt_next;
    logic          w_commit;

    // Strict compares: equality with either level leaves the bit unchanged.
    function automatic logic f_next_on(input logic on, input logic [WIDTH-1:0] v,
                                       input logic [WIDTH-1:0] th, input logic [WIDTH-1:0] lo);
        return on ? !(v < lo) : (v > th);
    endfunction

    always_comb begin
        w_next_on = r_on;
        if (sample_valid) begin
            w_next_on = {f_next_on(r_on[2], blue_norm,  SET_B, CLR_B),
                         f_next_on(r_on[1], green_norm, SET_G, CLR_G),
                         f_next_on(r_on[0], red_norm,   SET_R, CLR_R)};
        end
        if (w_next_on == r_cand) begin
            w_cnt_next = (r_cnt == SN_W) ? r_cnt : r_cnt + CW'(1);
        end else begin
            w_cnt_next = CW'(1);
        end
        w_commit = sample_valid && (w_cnt_next == SN_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_on     <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_change <= 1'b0;
            if (sample_valid) begin
                r_on   <= w_next_on;
                r_cand <= w_next_on;
                r_cnt  <= w_cnt_next;
                if (w_commit) begin
                    r_valid <= 1'b1;
                    if (w_next_on != r_code) begin
                        r_code   <= w_next_on;
                        r_change <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        color        = (ACTIVE_LOW != 0) ? ~r_code : r_code;
        color_valid  = r_valid;
        color_change = r_change;
    end

endmodule
